wb_stream_reader_ctrl: RTL and testbench
========================================

Name: wb_stream_reader_ctrl

Overview:
Wishbone burst-write master that drains a stream FIFO into a circular memory buffer. Companion to the stream writer controller, moving data in the opposite direction: stream sink FIFO -> memory. Waits until the FIFO holds a full burst, then issues linear incrementing write bursts from start_adr, wrapping at buf_size. Sits between the stream reader FIFO and the system Wishbone interconnect; configured by the stream reader's CSR block.

Parameters:
WB_AW, 32, Wishbone address width
WB_DW, 32, Wishbone data width (fixed at 32; wbm_sel_o is 4'hf)
FIFO_AW, 0, FIFO address width; must be > 0 (elaboration $error otherwise)
MAX_BURST_LEN, 0, largest supported burst_size in words; sizes burst counter to $clog2(MAX_BURST_LEN)+1 bits

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  asynchronous active-high reset
wbm_adr_o  out  WB_AW  byte address = start_adr + adr*4
wbm_dat_o  out  WB_DW  write data = fifo_d
wbm_sel_o  out  WB_DW/8  constant all-ones
wbm_we_o  out  1  constant 1
wbm_cyc_o  out  1  high in ACTIVE
wbm_stb_o  out  1  high in ACTIVE
wbm_cti_o  out  3  000 idle, 010 burst, 111 last beat
wbm_bte_o  out  2  constant 00
wbm_dat_i  in  WB_DW  unused
wbm_ack_i  in  1  beat accepted
wbm_err_i  in  1  bus error, aborts transfer
wbm_rty_i  in  1  unused, ignored
fifo_d  in  WB_DW  FIFO head word (first-word-fall-through)
fifo_rd  out  1  FIFO pop = wbm_ack_i & ACTIVE
fifo_cnt  in  FIFO_AW+1  words in FIFO
enable  in  1  level run request
start_adr  in  WB_AW  buffer base byte address (word aligned)
buf_size  in  WB_AW  buffer size in bytes, multiple of 4, >= 4
burst_size  in  WB_AW  words per burst, 1..MAX_BURST_LEN
busy  out  1  enable_r latched; buffer fill in progress
err  out  1  sticky bus-error flag

Behaviour:
- Reset (async, wb_rst_i=1): state=IDLE, adr=0, burst_cnt=0, enable_r=0, err=0; so cyc/stb=0, cti=000, fifo_rd=0, busy=0.
- Word index adr (WB_AW bits); last_adr = (adr == buf_size[WB_AW-1:2]-1). On ack: adr <= last_adr ? 0 : adr+1.
- burst_cnt cleared in IDLE, +1 per ack in ACTIVE. burst_end = (burst_cnt == burst_size-1) | last_adr: a burst never crosses buffer end; it is truncated at the last buffer word.
- cti combinational: !ACTIVE 000; burst_end 111; else 010.
- FSM IDLE: if enable & !enable_r -> enable_r<=1. If enable_r & !enable -> enable_r<=0, adr<=0 (stop at burst boundary only). If enable_r & enable & fifo_cnt >= burst_size & burst_size != 0 -> ACTIVE next cycle. burst_size=0: never starts.
- FSM ACTIVE: stb held until ack; data/address stable while waiting. On ack & burst_end -> IDLE; if also last_adr -> enable_r<=0 (buffer complete; new run needs enable high again, starting at adr=0).
- Error: wbm_err_i in ACTIVE -> IDLE, err<=1, enable_r<=0, adr<=0, no fifo_rd that cycle. err cleared only by reset or by enable rising from IDLE with enable_r=0.
- At least one IDLE cycle between bursts (cyc drops).
- enable deassert mid-burst: burst completes normally; stop takes effect in IDLE.
- busy = enable_r.
- Config inputs must be held stable while busy=1; changes mid-run are undefined.

Optional Feature:
Macro WB_STREAM_READER_IRQ_EN. Defined: adds output irq (1) and input irq_clr (1); irq sets on the cycle buffer completion (ack & last_adr) or on error, held until irq_clr=1 (clear wins over a simultaneous set); reset 0. Undefined: no irq/irq_clr ports, no extra logic.

Test Plan:
- Reset mid-burst (assert during beat 2 of 4) -> cyc/stb/cti=0 immediately, adr=0, busy=0.
- start_adr=0x1000, buf_size=32, burst_size=4, FIFO pre-filled with 8 words, enable=1 -> two 4-beat bursts at 0x1000-0x100C and 0x1010-0x101C, cti 010,010,010,111, 8 fifo_rd pulses, busy falls after last ack, adr wraps to 0.
- fifo_cnt=3, burst_size=4 -> no cyc; push 1 word -> burst starts the cycle after fifo_cnt=4.
- buf_size=24, burst_size=4 -> bursts of 4 then 2 beats, second ends cti=111 at 0x1014.
- Random ack wait states (0-3 cycles) -> adr/dat stable while stb & !ack, fifo_rd only on ack, memory image equals FIFO data order.
- err on beat 2 -> return to IDLE, err=1, busy=0, one fifo_rd only; with WB_STREAM_READER_IRQ_EN irq=1 until irq_clr.

Source files
------------

// File: rtl/wb_stream_reader_ctrl.sv
// Wishbone burst-write master that drains a stream FIFO into a circular memory buffer.
// Define WB_STREAM_READER_IRQ_EN to add the irq output and irq_clr input.
module wb_stream_reader_ctrl #(
    parameter int WB_AW         = 32,
    parameter int WB_DW         = 32,
    parameter int FIFO_AW       = 0,
    parameter int MAX_BURST_LEN = 0
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    output logic [WB_AW-1:0]     wbm_adr_o,
    output logic [WB_DW-1:0]     wbm_dat_o,
    output logic [WB_DW/8-1:0]   wbm_sel_o,
    output logic                 wbm_we_o,
    output logic                 wbm_cyc_o,
    output logic                 wbm_stb_o,
    output logic [2:0]           wbm_cti_o,
    output logic [1:0]           wbm_bte_o,
    input  logic [WB_DW-1:0]     wbm_dat_i,
    input  logic                 wbm_ack_i,
    input  logic                 wbm_err_i,
    input  logic                 wbm_rty_i,
    input  logic [WB_DW-1:0]     fifo_d,
    output logic                 fifo_rd,
    input  logic [FIFO_AW:0]     fifo_cnt,
    input  logic                 enable,
    input  logic [WB_AW-1:0]     start_adr,
    input  logic [WB_AW-1:0]     buf_size,
    input  logic [WB_AW-1:0]     burst_size,
    output logic                 busy,
    output logic                 err
`ifdef WB_STREAM_READER_IRQ_EN
    ,
    output logic                 irq,
    input  logic                 irq_clr
`endif
);

    localparam int BCW = $clog2(MAX_BURST_LEN) + 1;

    generate
        if (FIFO_AW <= 0) begin : g_fifo_aw_check
            $error("wb_stream_reader_ctrl: FIFO_AW must be greater than 0");
        end
    endgenerate

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WB_AW-1:0] adr_r;
    logic [WB_AW-1:0] adr_nxt_s;
    logic [BCW-1:0]   burst_cnt_r;
    logic [BCW-1:0]   burst_cnt_nxt_s;
    logic             enable_r;
    logic             enable_nxt_s;
    logic             err_r;
    logic             err_nxt_s;

    logic             active_s;
    logic [WB_AW-1:0] buf_words_s;
    logic             last_adr_s;
    logic             burst_end_s;
    logic             fifo_ready_s;
    logic [2:0]       cti_s;
    logic             unused_s;

    assign active_s     = (state_r == S_ACTIVE);
    assign buf_words_s  = {2'b00, buf_size[WB_AW-1:2]};
    assign last_adr_s   = (adr_r == (buf_words_s - WB_AW'(1'b1)));
    // A burst is cut short at the last buffer word so it never crosses the wrap point.
    assign burst_end_s  = (WB_AW'(burst_cnt_r) == (burst_size - WB_AW'(1'b1))) || last_adr_s;
    assign fifo_ready_s = (WB_AW'(fifo_cnt) >= burst_size) && (burst_size != {WB_AW{1'b0}});

    assign wbm_adr_o = start_adr + {adr_r[WB_AW-3:0], 2'b00};
    assign wbm_dat_o = fifo_d;
    assign wbm_sel_o = {(WB_DW/8){1'b1}};
    assign wbm_we_o  = 1'b1;
    assign wbm_cyc_o = active_s;
    assign wbm_stb_o = active_s;
    assign wbm_bte_o = 2'b00;
    assign wbm_cti_o = cti_s;
    assign fifo_rd   = active_s & wbm_ack_i & ~wbm_err_i;
    assign busy      = enable_r;
    assign err       = err_r;

    assign unused_s = ^{wbm_dat_i, wbm_rty_i, buf_size[1:0]};

    // Cycle type: end-of-burst marker on the closing beat.
    always_comb begin
        if (!active_s) begin
            cti_s = 3'b000;
        end else if (burst_end_s) begin
            cti_s = 3'b111;
        end else begin
            cti_s = 3'b010;
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_nxt_s     = state_r;
        adr_nxt_s       = adr_r;
        burst_cnt_nxt_s = burst_cnt_r;
        enable_nxt_s    = enable_r;
        err_nxt_s       = err_r;
        case (state_r)
            S_IDLE: begin
                burst_cnt_nxt_s = {BCW{1'b0}};
                if (enable && !enable_r) begin
                    enable_nxt_s = 1'b1;
                    err_nxt_s    = 1'b0;
                end else if (enable_r && !enable) begin
                    enable_nxt_s = 1'b0;
                    adr_nxt_s    = {WB_AW{1'b0}};
                end else if (enable_r && fifo_ready_s) begin
                    state_nxt_s = S_ACTIVE;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_ACTIVE: begin
                if (wbm_err_i) begin
                    state_nxt_s  = S_IDLE;
                    err_nxt_s    = 1'b1;
                    enable_nxt_s = 1'b0;
                    adr_nxt_s    = {WB_AW{1'b0}};
                end else if (wbm_ack_i) begin
                    burst_cnt_nxt_s = burst_cnt_r + BCW'(1'b1);
                    adr_nxt_s       = last_adr_s ? {WB_AW{1'b0}} : (adr_r + WB_AW'(1'b1));
                    if (burst_end_s) begin
                        state_nxt_s = S_IDLE;
                        // Completing the buffer ends the run; a new one restarts at word 0.
                        if (last_adr_s) begin
                            enable_nxt_s = 1'b0;
                        end else begin
                            enable_nxt_s = enable_r;
                        end
                    end else begin
                        state_nxt_s = S_ACTIVE;
                    end
                end else begin
                    state_nxt_s = S_ACTIVE;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // Controller state registers.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_r     <= S_IDLE;
            adr_r       <= {WB_AW{1'b0}};
            burst_cnt_r <= {BCW{1'b0}};
            enable_r    <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            adr_r       <= adr_nxt_s;
            burst_cnt_r <= burst_cnt_nxt_s;
            enable_r    <= enable_nxt_s;
            err_r       <= err_nxt_s;
        end
    end

`ifdef WB_STREAM_READER_IRQ_EN
    logic irq_r;
    logic irq_set_s;

    assign irq_set_s = active_s && (wbm_err_i || (wbm_ack_i && last_adr_s));
    assign irq       = irq_r;

    // Interrupt flag: set on buffer completion or bus error, clear has priority.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            irq_r <= 1'b0;
        end else if (irq_clr) begin
            irq_r <= 1'b0;
        end else if (irq_set_s) begin
            irq_r <= 1'b1;
        end else begin
            irq_r <= irq_r;
        end
    end
`endif

endmodule

// File: tb/tb_wb_stream_reader_ctrl.sv
// Self-checking bench for wb_stream_reader_ctrl: FIFO model, Wishbone slave with wait states, beat scoreboard.
module tb_wb_stream_reader_ctrl;

    typedef struct packed {
        logic [31:0] adr;
        logic [2:0]  cti;
    } beat_t;

    logic        wb_clk_i;
    logic        wb_rst_i;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic [2:0]  wbm_cti_o;
    logic [1:0]  wbm_bte_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    logic        wbm_err_i;
    logic        wbm_rty_i;
    logic [31:0] fifo_d;
    logic        fifo_rd;
    logic [4:0]  fifo_cnt;
    logic        enable;
    logic [31:0] start_adr;
    logic [31:0] buf_size;
    logic [31:0] burst_size;
    logic        busy;
    logic        err;
`ifdef WB_STREAM_READER_IRQ_EN
    logic        irq;
    logic        irq_clr;
`endif

    int          n_tests;
    int          n_fail;
    int          beat_no;
    int          rd_cnt;
    int          wait_left;
    int          err_beat;
    int unsigned ws_max;
    bit          stall;
    bit          hold_valid;
    bit          gap_due;
    logic [31:0] hold_adr;
    logic [31:0] hold_dat;
    logic [31:0] fifo_q[$];
    logic [31:0] exp_dat_q[$];
    beat_t       exp_beat_q[$];

    wb_stream_reader_ctrl #(
        .WB_AW(32),
        .WB_DW(32),
        .FIFO_AW(4),
        .MAX_BURST_LEN(8)
    ) dut (
        .wb_clk_i(wb_clk_i),
        .wb_rst_i(wb_rst_i),
        .wbm_adr_o(wbm_adr_o),
        .wbm_dat_o(wbm_dat_o),
        .wbm_sel_o(wbm_sel_o),
        .wbm_we_o(wbm_we_o),
        .wbm_cyc_o(wbm_cyc_o),
        .wbm_stb_o(wbm_stb_o),
        .wbm_cti_o(wbm_cti_o),
        .wbm_bte_o(wbm_bte_o),
        .wbm_dat_i(wbm_dat_i),
        .wbm_ack_i(wbm_ack_i),
        .wbm_err_i(wbm_err_i),
        .wbm_rty_i(wbm_rty_i),
        .fifo_d(fifo_d),
        .fifo_rd(fifo_rd),
        .fifo_cnt(fifo_cnt),
        .enable(enable),
        .start_adr(start_adr),
        .buf_size(buf_size),
        .burst_size(burst_size),
        .busy(busy),
        .err(err)
`ifdef WB_STREAM_READER_IRQ_EN
        ,
        .irq(irq),
        .irq_clr(irq_clr)
`endif
    );

    initial begin
        wb_clk_i = 1'b0;
        forever #5 wb_clk_i = ~wb_clk_i;
    end

    task automatic fifo_update();
        fifo_cnt = 5'(fifo_q.size());
        fifo_d   = (fifo_q.size() > 0) ? fifo_q[0] : 32'h0;
    endtask

    task automatic push_words(input int n);
        logic [31:0] w;
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            fifo_q.push_back(w);
            exp_dat_q.push_back(w);
        end
        fifo_update();
    endtask

    task automatic flush();
        fifo_q.delete();
        exp_dat_q.delete();
        exp_beat_q.delete();
        fifo_update();
    endtask

    task automatic reset_counters();
        beat_no    = 0;
        rd_cnt     = 0;
        wait_left  = -1;
        err_beat   = -1;
        stall      = 1'b0;
        hold_valid = 1'b0;
        gap_due    = 1'b0;
    endtask

    // Expected address/cti sequence of a run starting at word 0.
    task automatic expect_run(input logic [31:0] base, input int bytes, input int blen, input int n);
        int    a;
        int    c;
        int    words;
        beat_t b;
        a = 0;
        c = 0;
        words = bytes / 4;
        for (int i = 0; i < n; i++) begin
            b.adr = base + 32'(a * 4);
            if ((c == blen - 1) || (a == words - 1)) begin
                b.cti = 3'b111;
                c = 0;
            end else begin
                b.cti = 3'b010;
                c = c + 1;
            end
            a = (a == words - 1) ? 0 : a + 1;
            exp_beat_q.push_back(b);
        end
    endtask

    // One clock: drive slave response after the falling edge, then observe and score.
    task automatic tick();
        beat_t eb;
        logic [31:0] ed;
        @(negedge wb_clk_i);
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        if (wbm_cyc_o && wbm_stb_o && !stall) begin
            if (wait_left < 0) begin
                wait_left = int'($urandom_range(ws_max, 32'd0));
            end
            if (wait_left == 0) begin
                if (beat_no == err_beat) wbm_err_i = 1'b1;
                else wbm_ack_i = 1'b1;
                wait_left = -1;
            end else begin
                wait_left = wait_left - 1;
            end
        end
        #1;
        if (fifo_rd === 1'b1) rd_cnt++;
        if (gap_due) begin
            n_tests++;
            if (wbm_cyc_o !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_gap: cyc=%b after closing beat, required 0", wbm_cyc_o);
            end
            gap_due = 1'b0;
        end
        if (hold_valid && wbm_stb_o) begin
            n_tests++;
            if ((wbm_adr_o !== hold_adr) || (wbm_dat_o !== hold_dat)) begin
                n_fail++;
                $display("FAIL wait_stable: adr=%h dat=%h, required adr=%h dat=%h",
                         wbm_adr_o, wbm_dat_o, hold_adr, hold_dat);
            end
        end
        hold_valid = 1'b0;
        if (wbm_stb_o && wbm_ack_i) begin
            beat_no++;
            n_tests++;
            if (fifo_rd !== 1'b1) begin
                n_fail++;
                $display("FAIL fifo_rd_on_ack: got %b required 1", fifo_rd);
            end
            n_tests++;
            if (exp_beat_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_beat: adr=%h, required no beat", wbm_adr_o);
            end else begin
                eb = exp_beat_q.pop_front();
                if (wbm_adr_o !== eb.adr) begin
                    n_fail++;
                    $display("FAIL beat_adr: got %h required %h", wbm_adr_o, eb.adr);
                end
                n_tests++;
                if (wbm_cti_o !== eb.cti) begin
                    n_fail++;
                    $display("FAIL beat_cti: adr=%h got %b required %b", wbm_adr_o, wbm_cti_o, eb.cti);
                end
                gap_due = (eb.cti == 3'b111);
            end
            ed = (exp_dat_q.size() > 0) ? exp_dat_q.pop_front() : 32'h0;
            n_tests++;
            if (wbm_dat_o !== ed) begin
                n_fail++;
                $display("FAIL beat_dat: adr=%h got %h required %h", wbm_adr_o, wbm_dat_o, ed);
            end
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
            fifo_update();
        end else if (wbm_stb_o && wbm_err_i) begin
            beat_no++;
            n_tests++;
            if (fifo_rd !== 1'b0) begin
                n_fail++;
                $display("FAIL fifo_rd_on_err: got %b required 0", fifo_rd);
            end
        end else if (wbm_stb_o) begin
            hold_valid = 1'b1;
            hold_adr   = wbm_adr_o;
            hold_dat   = wbm_dat_o;
        end else begin
            n_tests++;
            if ((wbm_cti_o !== 3'b000) || (fifo_rd !== 1'b0)) begin
                n_fail++;
                $display("FAIL idle_outputs: cti=%b fifo_rd=%b, required 000/0", wbm_cti_o, fifo_rd);
            end
        end
    endtask

    task automatic run_beats(input int target, input int budget);
        for (int i = 0; (i < budget) && (beat_no < target); i++) tick();
        if (beat_no < target) begin
            n_tests++;
            n_fail++;
            $display("FAIL beat_timeout: got %0d beats required %0d", beat_no, target);
        end
    endtask

    task automatic settle();
        enable = 1'b0;
        repeat (3) tick();
        flush();
    endtask

    task automatic check_drained(input int rd_req);
        n_tests++;
        if (exp_beat_q.size() != 0) begin
            n_fail++;
            $display("FAIL beats_missing: %0d left, required 0", exp_beat_q.size());
        end
        n_tests++;
        if (rd_cnt !== rd_req) begin
            n_fail++;
            $display("FAIL fifo_rd_count: got %0d required %0d", rd_cnt, rd_req);
        end
    endtask

    task automatic test_reset();
        start_adr  = 32'h0000_1000;
        buf_size   = 32'd32;
        burst_size = 32'd4;
        enable     = 1'b0;
        wb_rst_i   = 1'b1;
        reset_counters();
        repeat (2) tick();
        n_tests++;
        if ((wbm_cyc_o !== 1'b0) || (wbm_stb_o !== 1'b0) || (busy !== 1'b0) || (err !== 1'b0)) begin
            n_fail++;
            $display("FAIL reset_state: cyc=%b stb=%b busy=%b err=%b required 0000",
                     wbm_cyc_o, wbm_stb_o, busy, err);
        end
        n_tests++;
        if (wbm_adr_o !== 32'h0000_1000) begin
            n_fail++;
            $display("FAIL reset_adr: got %h required 00001000", wbm_adr_o);
        end
        n_tests++;
        if ((wbm_sel_o !== 4'hf) || (wbm_we_o !== 1'b1) || (wbm_bte_o !== 2'b00)) begin
            n_fail++;
            $display("FAIL const_outputs: sel=%h we=%b bte=%b required f/1/00", wbm_sel_o, wbm_we_o, wbm_bte_o);
        end
        wb_rst_i = 1'b0;
        repeat (2) tick();
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_busy: got %b required 0", busy);
        end
    endtask

    task automatic test_two_bursts();
        reset_counters();
        ws_max     = 0;
        start_adr  = 32'h0000_1000;
        buf_size   = 32'd32;
        burst_size = 32'd4;
        push_words(8);
        expect_run(32'h0000_1000, 32, 4, 8);
        enable = 1'b1;
        run_beats(8, 100);
        tick();
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_after_buffer: got %b required 0", busy);
        end
        enable = 1'b0;
        n_tests++;
        if (wbm_adr_o !== 32'h0000_1000) begin
            n_fail++;
            $display("FAIL adr_wrap: got %h required 00001000", wbm_adr_o);
        end
        check_drained(8);
        settle();
    endtask

    task automatic test_fifo_threshold();
        reset_counters();
        start_adr = 32'h0000_2000;
        push_words(3);
        enable = 1'b1;
        repeat (8) tick();
        n_tests++;
        if ((beat_no !== 0) || (wbm_cyc_o !== 1'b0) || (busy !== 1'b1)) begin
            n_fail++;
            $display("FAIL below_threshold: beats=%0d cyc=%b busy=%b required 0/0/1", beat_no, wbm_cyc_o, busy);
        end
        expect_run(32'h0000_2000, 32, 4, 4);
        push_words(1);
        tick();
        n_tests++;
        if (wbm_cyc_o !== 1'b1) begin
            n_fail++;
            $display("FAIL start_at_threshold: cyc=%b required 1", wbm_cyc_o);
        end
        run_beats(4, 50);
        check_drained(4);
        settle();
    endtask

    task automatic test_truncated_burst();
        reset_counters();
        start_adr = 32'h0000_1000;
        buf_size  = 32'd24;
        push_words(8);
        expect_run(32'h0000_1000, 24, 4, 6);
        enable = 1'b1;
        run_beats(6, 100);
        tick();
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_after_truncated: got %b required 0", busy);
        end
        enable = 1'b0;
        check_drained(6);
        settle();
    endtask

    task automatic test_wait_states();
        reset_counters();
        ws_max     = 3;
        start_adr  = 32'h0000_3000;
        buf_size   = 32'd16;
        burst_size = 32'd3;
        push_words(8);
        expect_run(32'h0000_3000, 16, 3, 4);
        expect_run(32'h0000_3000, 16, 3, 3);
        enable = 1'b1;
        run_beats(7, 400);
        repeat (4) tick();
        check_drained(7);
        settle();
        ws_max = 0;
    endtask

    task automatic test_error();
        reset_counters();
        start_adr  = 32'h0000_4000;
        buf_size   = 32'd32;
        burst_size = 32'd4;
        err_beat   = 1;
        push_words(4);
        expect_run(32'h0000_4000, 32, 4, 1);
        enable = 1'b1;
        run_beats(1, 50);
        enable = 1'b0;
        run_beats(2, 10);
        tick();
        n_tests++;
        if ((err !== 1'b1) || (busy !== 1'b0) || (wbm_cyc_o !== 1'b0)) begin
            n_fail++;
            $display("FAIL error_abort: err=%b busy=%b cyc=%b required 1/0/0", err, busy, wbm_cyc_o);
        end
        n_tests++;
        if (wbm_adr_o !== 32'h0000_4000) begin
            n_fail++;
            $display("FAIL error_adr: got %h required 00004000", wbm_adr_o);
        end
        check_drained(1);
`ifdef WB_STREAM_READER_IRQ_EN
        tick();
        n_tests++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL irq_held: got %b required 1", irq);
        end
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        n_tests++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_clear: got %b required 0", irq);
        end
`endif
        flush();
        err_beat = -1;
        enable   = 1'b1;
        tick();
        n_tests++;
        if ((err !== 1'b0) || (busy !== 1'b1)) begin
            n_fail++;
            $display("FAIL error_clear: err=%b busy=%b required 0/1", err, busy);
        end
        settle();
    endtask

    task automatic test_reset_mid_burst();
        reset_counters();
        start_adr  = 32'h0000_5000;
        buf_size   = 32'd32;
        burst_size = 32'd4;
        push_words(4);
        expect_run(32'h0000_5000, 32, 4, 1);
        enable = 1'b1;
        run_beats(1, 50);
        stall = 1'b1;
        tick();
        n_tests++;
        if (wbm_stb_o !== 1'b1) begin
            n_fail++;
            $display("FAIL beat2_pending: stb=%b required 1", wbm_stb_o);
        end
        wb_rst_i = 1'b1;
        #1;
        n_tests++;
        if ((wbm_cyc_o !== 1'b0) || (wbm_stb_o !== 1'b0) || (wbm_cti_o !== 3'b000) ||
            (busy !== 1'b0) || (fifo_rd !== 1'b0)) begin
            n_fail++;
            $display("FAIL async_reset: cyc=%b stb=%b cti=%b busy=%b rd=%b required all 0",
                     wbm_cyc_o, wbm_stb_o, wbm_cti_o, busy, fifo_rd);
        end
        n_tests++;
        if (wbm_adr_o !== 32'h0000_5000) begin
            n_fail++;
            $display("FAIL async_reset_adr: got %h required 00005000", wbm_adr_o);
        end
        enable = 1'b0;
        reset_counters();
        tick();
        wb_rst_i = 1'b0;
        flush();
        repeat (2) tick();
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_busy: got %b required 0", busy);
        end
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        ws_max     = 0;
        wb_rst_i   = 1'b1;
        wbm_ack_i  = 1'b0;
        wbm_err_i  = 1'b0;
        wbm_rty_i  = 1'b0;
        wbm_dat_i  = 32'h0;
        enable     = 1'b0;
        start_adr  = 32'h0;
        buf_size   = 32'd32;
        burst_size = 32'd4;
`ifdef WB_STREAM_READER_IRQ_EN
        irq_clr    = 1'b0;
`endif
        reset_counters();
        fifo_update();
        test_reset();
        test_two_bursts();
        test_fifo_threshold();
        test_truncated_burst();
        test_wait_states();
        test_error();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
